mac_vec_acc: RTL and testbench
==============================

MAC_VEC_ACC -- requirements
Module: mac_vec_acc

Interface
REQ-001 SHALL have parameter INPUT_BITWIDTH, default 16, meaning the signed width of a_in, w_in and bias_in.
REQ-002 SHALL have parameter ACC_BITWIDTH, default 40, meaning the signed accumulator/result width; legal range is >= 2*INPUT_BITWIDTH.
REQ-003 SHALL have parameter VEC_LEN, default 64, meaning the number of products per dot product; legal range is >= 1.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: a_in/w_in/bias_in are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-008 SHALL have port a_in, input, INPUT_BITWIDTH bits: signed activation.
REQ-009 SHALL have port w_in, input, INPUT_BITWIDTH bits: signed weight.
REQ-010 SHALL have port bias_in, input, INPUT_BITWIDTH bits: signed bias, sampled only with the first term of a vector.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port out, output, ACC_BITWIDTH bits: signed dot-product result.
REQ-014 SHALL have port sat_flag, output, 1 bit: the accumulator saturated during the current vector.

Function
REQ-015 SHALL accept a term only when in_valid and in_ready are both 1 on a rising edge; in_valid low cycles are bubbles and advance nothing.
REQ-016 SHALL implement a 2-stage pipeline: stage 1 registers the full-precision signed a_in*w_in (2*INPUT_BITWIDTH bits) with a valid bit; stage 2 sign-extends the product to ACC_BITWIDTH and adds it to the accumulator.
REQ-017 SHALL, for the first term of a vector, load the accumulator with sign-extended bias_in plus the product instead of adding to the prior value.
REQ-018 SHALL count accepted terms with a counter of width $clog2(VEC_LEN+1); the counter resets to 0 when a result is handed off.
REQ-019 SHALL implement the FSM IDLE -> ACCUM on the first accepted term, ACCUM -> DRAIN when the VEC_LEN-th term is accepted, DRAIN -> HOLD once the last product is added (1 cycle), and HOLD -> IDLE on out_valid and out_ready.
REQ-020 SHALL skip ACCUM when VEC_LEN=1, going IDLE -> DRAIN on the single accepted term.
REQ-021 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in DRAIN and HOLD.
REQ-022 SHALL drive out_valid=1 only in HOLD; out and sat_flag SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 SHALL give a latency of 2 cycles: last term accepted at edge T, out_valid high after edge T+2.
REQ-024 SHALL, after the handshake edge, return in_ready to 1 in the following cycle; the minimum vector period is VEC_LEN+3 cycles.
REQ-025 SHALL ignore out_ready outside HOLD.
REQ-026 SHALL leave out holding the last result in IDLE and ACCUM; its value is qualified only by out_valid.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, term counter=0, stage-1 valid=0, accumulator=0, out=0, sat_flag=0 and out_valid=0; in_ready SHALL be 1 after rst deasserts.
REQ-028 SHALL, on rst asserted mid-vector or in HOLD, discard the partial or pending result, and the next accepted term SHALL start a new vector with bias.

Configuration
REQ-029 SHALL, with MAC_SAT_EN defined, clamp every stage-2 addition that overflows to the signed ACC_BITWIDTH max/min and set sat_flag sticky for the vector; sat_flag clears when the next vector's first product is added.
REQ-030 SHALL, without MAC_SAT_EN, wrap stage-2 additions modulo 2^ACC_BITWIDTH, with sat_flag tied to 0.

Verification (INPUT_BITWIDTH=16, ACC_BITWIDTH=40, VEC_LEN=4 unless stated)
REQ-031 SHALL cover back-to-back terms: a=1,2,3,4; w=5,6,7,8; bias=10 -> out=80 with out_valid two cycles after the 4th term and in_ready=0 in DRAIN and HOLD.
REQ-032 SHALL cover signed operands and bubbles: a=-3,-32768,7,0; w=4,-32768,-2,9; bias=-1; in_valid low every other cycle -> out=1073741797.
REQ-033 SHALL cover backpressure: out_ready low for 5 cycles in HOLD -> out and out_valid stable and in_ready=0 throughout; the handshake is followed by in_ready=1 on the next cycle.
REQ-034 SHALL cover reset mid-vector: rst pulse after 2 terms, then 4 terms a=1, w=1, bias=0 -> out=4.
REQ-035 SHALL cover saturation with ACC_BITWIDTH=32: 4 terms of a=w=-32768, bias=32767 -> with MAC_SAT_EN, out=2147483647 and sat_flag=1; without it, out equals the 32-bit wrapped sum and sat_flag=0.
REQ-036 SHALL cover VEC_LEN=1: a=-2, w=3, bias=5 -> out=-1 two cycles after acceptance, then a new vector is accepted immediately after the handshake.

Source files
------------

// File: rtl/mac_vec_acc.sv
// Pipelined signed multiply-accumulate over VEC_LEN-term vectors with valid/ready handshakes on both sides.
// Optional feature: define MAC_SAT_EN for saturating accumulation with a sticky sat_flag (default build wraps).
module mac_vec_acc #(
   parameter int INPUT_BITWIDTH = 16,
   parameter int ACC_BITWIDTH   = 40,
   parameter int VEC_LEN        = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic signed [INPUT_BITWIDTH-1:0] a_in,
   input  logic signed [INPUT_BITWIDTH-1:0] w_in,
   input  logic signed [INPUT_BITWIDTH-1:0] bias_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic signed [ACC_BITWIDTH-1:0]   out,
   output logic                             sat_flag
);

   localparam int PW = 2 * INPUT_BITWIDTH;
   localparam int CW = $clog2(VEC_LEN + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(VEC_LEN - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   state_t                            state;
   logic [CW-1:0]                     count;
   logic signed [PW-1:0]              prod;
   logic                              prod_valid;
   logic                              prod_first;
   logic signed [INPUT_BITWIDTH-1:0]  bias_q;
   logic signed [ACC_BITWIDTH-1:0]    acc;
   logic signed [ACC_BITWIDTH-1:0]    acc_base;
   logic signed [ACC_BITWIDTH-1:0]    prod_ext;
   logic signed [ACC_BITWIDTH-1:0]    acc_next;
   logic                              accept;

   assign accept = in_valid && in_ready;

   // The first product of a vector starts from the bias instead of the running sum.
   always_comb begin
      prod_ext = ACC_BITWIDTH'(prod);
      acc_base = prod_first ? ACC_BITWIDTH'(bias_q) : acc;
   end

`ifdef MAC_SAT_EN
   localparam logic signed [ACC_BITWIDTH-1:0] ACC_MAX = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
   localparam logic signed [ACC_BITWIDTH-1:0] ACC_MIN = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};

   logic signed [ACC_BITWIDTH:0] sum_wide;
   logic                         overflow;

   always_comb begin
      sum_wide = (ACC_BITWIDTH+1)'(acc_base) + (ACC_BITWIDTH+1)'(prod_ext);
      overflow = sum_wide[ACC_BITWIDTH] != sum_wide[ACC_BITWIDTH-1];
      acc_next = sum_wide[ACC_BITWIDTH-1:0];
      if (overflow) begin
         acc_next = sum_wide[ACC_BITWIDTH] ? ACC_MIN : ACC_MAX;
      end
   end

   // Sticky for the whole vector; the first product of a new vector restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flag <= 1'b0;
      end else if (prod_valid) begin
         sat_flag <= prod_first ? overflow : (sat_flag | overflow);
      end
   end
`else
   always_comb begin
      acc_next = acc_base + prod_ext;
   end

   assign sat_flag = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         prod       <= '0;
         prod_valid <= 1'b0;
         prod_first <= 1'b0;
         bias_q     <= '0;
         acc        <= '0;
         out        <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         prod_valid <= accept;
         if (accept) begin
            prod       <= PW'(a_in) * PW'(w_in);
            prod_first <= (count == '0);
            count      <= count + CW'(1);
            if (count == '0) begin
               bias_q <= bias_in;
            end
         end

         if (prod_valid) begin
            acc <= acc_next;
         end

         // DRAIN waits for stage 1 to empty, so out captures the fully summed accumulator.
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  if (count == LAST_COUNT) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            DRAIN: begin
               if (!prod_valid) begin
                  state     <= HOLD;
                  out       <= acc;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  count     <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Directed self-checking bench for mac_vec_acc: VEC_LEN=4 and VEC_LEN=1 instances at 40-bit accumulation,
// plus a 32-bit instance for saturation/wrap behaviour (expectations follow MAC_SAT_EN).
module tb_mac_vec_acc;

   logic clk;
   logic rst;
   logic in_valid;
   logic out_ready;
   logic signed [15:0] a_in;
   logic signed [15:0] w_in;
   logic signed [15:0] bias_in;

   logic in_ready4, out_valid4, sat4;
   logic signed [39:0] out4;
   logic in_ready32, out_valid32, sat32;
   logic signed [31:0] out32;
   logic in_ready1, out_valid1, sat1;
   logic signed [39:0] out1;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [0:3][15:0] a;
      logic [0:3][15:0] w;
      logic [15:0]      bias;
      bit               bubbles;
      longint           expected;
   } vec_t;

   vec_t tbl[3];
   vec_t onesVec;
   vec_t satVec;

   mac_vec_acc #(.INPUT_BITWIDTH(16), .ACC_BITWIDTH(40), .VEC_LEN(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .a_in(a_in), .w_in(w_in), .bias_in(bias_in),
      .out_valid(out_valid4), .out_ready(out_ready), .out(out4), .sat_flag(sat4)
   );

   mac_vec_acc #(.INPUT_BITWIDTH(16), .ACC_BITWIDTH(32), .VEC_LEN(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .a_in(a_in), .w_in(w_in), .bias_in(bias_in),
      .out_valid(out_valid32), .out_ready(out_ready), .out(out32), .sat_flag(sat32)
   );

   mac_vec_acc #(.INPUT_BITWIDTH(16), .ACC_BITWIDTH(40), .VEC_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .a_in(a_in), .w_in(w_in), .bias_in(bias_in),
      .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .sat_flag(sat1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic resetPulse();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      #2;
      rst       = 1'b0;
   endtask

   // Drives the four terms of a vector, optionally with a bubble before every term but the first.
   task automatic applyStimulus(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         if (v.bubbles && i > 0) begin
            in_valid = 1'b0;
            step();
         end
         in_valid = 1'b1;
         a_in     = v.a[i];
         w_in     = v.w[i];
         bias_in  = v.bias;
         checkOutput("term_in_ready", in_ready4, 1);
         step();
      end
      in_valid = 1'b0;
   endtask

   // Full vector on the VEC_LEN=4 instance: drain, latency, optional backpressure, handshake.
   task automatic runVector4(input vec_t v, input int holdCycles);
      applyStimulus(v);
      checkOutput("drain_in_ready", in_ready4, 0);
      checkOutput("drain_out_valid", out_valid4, 0);
      step();
      checkOutput("drain2_in_ready", in_ready4, 0);
      checkOutput("drain2_out_valid", out_valid4, 0);
      step();
      checkOutput("latency_out_valid", out_valid4, 1);
      checkOutput("result", out4, v.expected);
      checkOutput("hold_in_ready", in_ready4, 0);
      for (int h = 0; h < holdCycles; h++) begin
         step();
         checkOutput("bp_out_valid", out_valid4, 1);
         checkOutput("bp_out", out4, v.expected);
         checkOutput("bp_in_ready", in_ready4, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("post_hs_out_valid", out_valid4, 0);
      checkOutput("post_hs_in_ready", in_ready4, 1);
      checkOutput("post_hs_out_held", out4, v.expected);
   endtask

   initial begin
      longint expSat;
      longint expSatFlag;
      longint fullSum;

      tbl[0].a = {16'sd1, 16'sd2, 16'sd3, 16'sd4};
      tbl[0].w = {16'sd5, 16'sd6, 16'sd7, 16'sd8};
      tbl[0].bias = 16'sd10;
      tbl[0].bubbles = 1'b0;
      tbl[0].expected = 80;

      tbl[1].a = {-16'sd3, 16'h8000, 16'sd7, 16'sd0};
      tbl[1].w = {16'sd4, 16'h8000, -16'sd2, 16'sd9};
      tbl[1].bias = -16'sd1;
      tbl[1].bubbles = 1'b1;
      tbl[1].expected = 1073741797;

      tbl[2].a = {16'sd100, -16'sd200, 16'sd300, -16'sd400};
      tbl[2].w = {-16'sd5, 16'sd6, 16'sd7, -16'sd8};
      tbl[2].bias = -16'sd7;
      tbl[2].bubbles = 1'b0;
      tbl[2].expected = 3593;

      onesVec.a = {16'sd1, 16'sd1, 16'sd1, 16'sd1};
      onesVec.w = {16'sd1, 16'sd1, 16'sd1, 16'sd1};
      onesVec.bias = 16'sd0;
      onesVec.bubbles = 1'b0;
      onesVec.expected = 4;

      satVec.a = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
      satVec.w = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
      satVec.bias = 16'sd32767;
      satVec.bubbles = 1'b0;

      fullSum = 4 * 64'sd1073741824 + 64'sd32767;
`ifdef MAC_SAT_EN
      expSat     = 2147483647;
      expSatFlag = 1;
`else
      expSat     = longint'($signed(fullSum[31:0]));
      expSatFlag = 0;
`endif
      satVec.expected = expSat;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      w_in      = '0;
      bias_in   = '0;
      repeat (2) step();
      rst = 1'b0;
      checkOutput("reset_in_ready", in_ready4, 1);
      checkOutput("reset_out_valid", out_valid4, 0);
      checkOutput("reset_out", out4, 0);
      checkOutput("reset_sat_flag", sat4, 0);

      for (int t = 0; t < 3; t++) begin
         runVector4(tbl[t], 0);
      end

      runVector4(tbl[0], 5);

      // Reset after two terms must discard them; the next vector starts fresh with its bias.
      resetPulse();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         a_in     = 16'sd5;
         w_in     = 16'sd5;
         bias_in  = 16'sd9;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out", out4, 0);
      checkOutput("midrst_out_valid", out_valid4, 0);
      checkOutput("midrst_sat_flag", sat4, 0);
      rst = 1'b0;
      runVector4(onesVec, 0);

      // Saturation / wrap on the 32-bit accumulator, then the flag must clear on a clean vector.
      resetPulse();
      applyStimulus(satVec);
      step();
      step();
      checkOutput("sat_out_valid", out_valid32, 1);
      checkOutput("sat_out", out32, satVec.expected);
      checkOutput("sat_flag", sat32, expSatFlag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      applyStimulus(onesVec);
      step();
      step();
      checkOutput("sat_clear_out_valid", out_valid32, 1);
      checkOutput("sat_clear_out", out32, 4);
      checkOutput("sat_clear_flag", sat32, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Single-term vectors: the first term is also the last.
      resetPulse();
      in_valid = 1'b1;
      a_in     = -16'sd2;
      w_in     = 16'sd3;
      bias_in  = 16'sd5;
      step();
      in_valid = 1'b0;
      checkOutput("v1_drain_in_ready", in_ready1, 0);
      checkOutput("v1_drain_out_valid", out_valid1, 0);
      step();
      checkOutput("v1_drain2_out_valid", out_valid1, 0);
      step();
      checkOutput("v1_out_valid", out_valid1, 1);
      checkOutput("v1_out", out1, -1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("v1_post_hs_in_ready", in_ready1, 1);
      in_valid = 1'b1;
      a_in     = 16'sd4;
      w_in     = 16'sd4;
      bias_in  = 16'sd1;
      step();
      in_valid = 1'b0;
      checkOutput("v1_second_accepted", in_ready1, 0);
      step();
      step();
      checkOutput("v1_second_out_valid", out_valid1, 1);
      checkOutput("v1_second_out", out1, 17);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
